// File: rtl/nn_inference_sequencer.sv
// Inference sequencer: load 784 pixels, run the two-layer datapath, argmax the outputs, hand off result.
// Optional RUN-phase watchdog enabled by defining NN_SEQ_TIMEOUT_EN.
module nn_inference_sequencer #(
  parameter int unsigned NUM_PIXELS     = 784,
  parameter int unsigned PIX_W          = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned NUM_CLASSES    = 10,
  parameter int unsigned OUT_W          = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  input  logic                    pix_valid,
  input  logic [PIX_W-1:0]        pix_data,
  output logic                    pix_ready,
  output logic                    buf_we,
  output logic [ADDR_W-1:0]       buf_addr,
  output logic [PIX_W-1:0]        buf_wdata,
  output logic                    l1_run,
  input  logic                    l1_done,
  input  logic                    l2_done,
  output logic [3:0]              out_sel,
  input  logic signed [OUT_W-1:0] out_data,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [3:0]              result_class,
  output logic signed [OUT_W-1:0] result_score,
  output logic                    err
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StArgmax, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NUM_PIXELS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [3:0]              out_sel_q, out_sel_d;
  logic                    pvalid_q, pvalid_d;
  logic [3:0]              pidx_q, pidx_d;
  logic signed [OUT_W-1:0] pdata_q, pdata_d;
  logic [3:0]              class_q, class_d;
  logic signed [OUT_W-1:0] score_q, score_d;
  logic                    busy_q, busy_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    l1_run_q, l1_run_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic                    timeout;

`ifdef NN_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counter is held at zero outside RUN, so every RUN entry starts from zero.
  always_comb begin
    tmo_d   = (state_q == StRun) ? tmo_q + 1'b1 : '0;
    timeout = (state_q == StRun) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
`endif

  assign buf_we    = pix_valid & pix_ready_q;
  assign buf_wdata = pix_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_sel_d = out_sel_q;
    pvalid_d  = 1'b0;
    pidx_d    = out_sel_q;
    pdata_d   = out_data;
    class_d   = class_q;
    score_d   = score_q;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (buf_we) begin
          if (cnt_q == LastPix) state_d = StRun;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Requiring both in the same cycle discards an early, stale l2_done.
        if (l1_done && l2_done) begin
          state_d   = StArgmax;
          cnt_d     = '0;
          out_sel_d = '0;
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
          class_d = 4'hF;
          score_d = '0;
        end
      end
      StArgmax: begin
        if (cnt_q < ADDR_W'(NUM_CLASSES)) begin
          cnt_d    = cnt_q + 1'b1;
          pvalid_d = 1'b1;
          if (cnt_q < ADDR_W'(NUM_CLASSES - 1)) out_sel_d = out_sel_q + 4'd1;
        end
        // Stage 2 compares the output registered last cycle; strict > keeps the lowest index on ties.
        if (pvalid_q) begin
          if ((pidx_q == 4'd0) || (pdata_q > score_q)) begin
            class_d = pidx_q;
            score_d = pdata_q;
          end
          if (pidx_q == 4'(NUM_CLASSES - 1)) state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d != StIdle);
    pix_ready_d = (state_d == StLoad);
    l1_run_d    = (state_d == StRun) || (state_d == StArgmax);
    rvalid_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_sel_q   <= '0;
      pvalid_q    <= 1'b0;
      pidx_q      <= '0;
      pdata_q     <= '0;
      class_q     <= '0;
      score_q     <= '0;
      busy_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      l1_run_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_sel_q   <= out_sel_d;
      pvalid_q    <= pvalid_d;
      pidx_q      <= pidx_d;
      pdata_q     <= pdata_d;
      class_q     <= class_d;
      score_q     <= score_d;
      busy_q      <= busy_d;
      pix_ready_q <= pix_ready_d;
      l1_run_q    <= l1_run_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  assign busy         = busy_q;
  assign pix_ready    = pix_ready_q;
  assign buf_addr     = cnt_q;
  assign l1_run       = l1_run_q;
  assign out_sel      = out_sel_q;
  assign result_valid = rvalid_q;
  assign result_class = class_q;
  assign result_score = score_q;
  assign err          = err_q;

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Scoreboard bench for nn_inference_sequencer: write and result queues checked by a negedge monitor.
module tb_nn_inference_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               busy;
  logic               pix_valid = 1'b0;
  logic [31:0]        pix_data = '0;
  logic               pix_ready;
  logic               buf_we;
  logic [9:0]         buf_addr;
  logic [31:0]        buf_wdata;
  logic               l1_run;
  logic               l1_done = 1'b0;
  logic               l2_done = 1'b0;
  logic [3:0]         out_sel;
  logic signed [63:0] out_data;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic [3:0]         result_class;
  logic signed [63:0] result_score;
  logic               err;

  logic signed [63:0] outs [10];

  typedef struct packed {logic [9:0] addr; logic [31:0] data;} wr_t;
  typedef struct packed {logic [3:0] cls; logic [63:0] score;} res_t;
  wr_t  wr_q [$];
  res_t res_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign out_data = (out_sel < 4'd10) ? outs[out_sel] : 64'sd0;

  nn_inference_sequencer #(
    .NUM_PIXELS    (784),
    .PIX_W         (32),
    .ADDR_W        (10),
    .NUM_CLASSES   (10),
    .OUT_W         (64),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_wdata   (buf_wdata),
    .l1_run      (l1_run),
    .l1_done     (l1_done),
    .l2_done     (l2_done),
    .out_sel     (out_sel),
    .out_data    (out_data),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_class(result_class),
    .result_score(result_score),
    .err         (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every buffer write and every result handshake is matched against the queues.
  always @(negedge clk) begin
    if (!rst && buf_we) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write", buf_addr);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("write_addr", 64'(buf_addr), 64'(e.addr));
        chk("write_data", 64'(buf_wdata), 64'(e.data));
      end
    end
    if (!rst && result_valid && result_ready) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got class %0d expected no result", result_class);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("result_class", 64'(result_class), 64'(r.cls));
        chk("result_score", result_score, r.score);
      end
    end
  end

  task automatic push_pixels(input int n);
    for (int i = 0; i < n; i++) wr_q.push_back('{addr: 10'(i), data: 32'(i * 3 + 7)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle, input bit l2_pulse);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < n && cyc < 4000) begin
      pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      pix_data  = 32'(i * 3 + 7);
      l2_done   = l2_pulse && (i == 100);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    pix_valid = 1'b0;
    l2_done   = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", i, n);
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (result_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL result_valid_timeout: got none expected within %0d cycles", limit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    outs = '{default: 64'sd0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_buf_we", 64'(buf_we), 64'd0);
    chk("rst_buf_addr", 64'(buf_addr), 64'd0);
    chk("rst_l1_run", 64'(l1_run), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result", {56'd0, result_class, 4'd0} | 64'(result_score), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Test 1: full-rate stream, stale l2_done and ignored start in RUN, tie-breaking argmax.
    outs = '{64'sd5, -64'sd3, 64'sd9, 64'sd9, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
    @(posedge clk); #1;
    push_pixels(784);
    pulse_start();
    stream(784, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_pix_ready_after", 64'(pix_ready), 64'd0);
    chk("t1_busy_run", 64'(busy), 64'd1);
    chk("t1_l1_run", 64'(l1_run), 64'd1);
    chk("t1_writes_left", 64'(wr_q.size()), 64'd0);
    @(posedge clk); #1;
    l2_done = 1'b1;
    @(posedge clk); #1;
    l2_done = 1'b0;
    pulse_start();
    repeat (15) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_stale_l2_no_adv", 64'(result_valid), 64'd0);
    chk("t1_still_running", 64'(l1_run), 64'd1);
    chk("t1_err_quiet", 64'(err), 64'd0);
    @(posedge clk); #1;
    l1_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_l1_alone_no_adv", 64'(result_valid), 64'd0);
    @(posedge clk); #1;
    res_q.push_back('{cls: 4'd2, score: 64'sd9});
    l2_done = 1'b1;
    wait_valid(40, n);
    chk("t1_argmax_latency", 64'(n), 64'd13);
    chk("t1_l1_run_done", 64'(l1_run), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_hold_valid", 64'(result_valid), 64'd1);
      chk("t1_hold_class", 64'(result_class), 64'd2);
      chk("t1_hold_score", result_score, 64'sd9);
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    l1_done = 1'b0;
    l2_done = 1'b0;
    @(negedge clk);
    chk("t1_idle_after", 64'(busy), 64'd0);
    chk("t1_results_left", 64'(res_q.size()), 64'd0);

    // Test 2: toggling stream with l2_done during LOAD, all-negative outputs, start at handshake.
    outs = '{-64'sd10, -64'sd2, -64'sd7, -64'sd5, -64'sd9, -64'sd3, -64'sd8, -64'sd4, -64'sd6,
             -64'sd11};
    @(posedge clk); #1;
    push_pixels(784);
    pulse_start();
    stream(784, 1'b1, 1'b1);
    chk("t2_writes_left", 64'(wr_q.size()), 64'd0);
    res_q.push_back('{cls: 4'd1, score: 64'(-64'sd2)});
    result_ready = 1'b1;
    l1_done = 1'b1;
    l2_done = 1'b1;
    wait_valid(40, n);
    chk("t2_argmax_latency", 64'(n), 64'd13);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l1_done = 1'b0;
    l2_done = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    chk("t2_start_at_handshake_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t2_start_not_captured", 64'(pix_ready), 64'd0);
    chk("t2_results_left", 64'(res_q.size()), 64'd0);

    // Test 3: rst mid-LOAD at pixel 400, then a clean restart from address 0.
    @(posedge clk); #1;
    push_pixels(784);
    pulse_start();
    stream(400, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t3_rst_busy", 64'(busy), 64'd0);
    chk("t3_rst_l1_run", 64'(l1_run), 64'd0);
    chk("t3_rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("t3_rst_addr", 64'(buf_addr), 64'd0);
    chk("t3_partial_writes", 64'(wr_q.size()), 64'd384);
    wr_q.delete();
    outs = '{64'sd1, -64'sd1, 64'sd3, 64'sd2, 64'sd3, 64'sd0, 64'sd7, 64'sd6, 64'sd5,
             64'sh7fff_ffff_ffff_ffff};
    @(posedge clk); #1;
    push_pixels(784);
    pulse_start();
    stream(784, 1'b0, 1'b0);
    chk("t3_writes_left", 64'(wr_q.size()), 64'd0);
    res_q.push_back('{cls: 4'd9, score: 64'h7fff_ffff_ffff_ffff});
    result_ready = 1'b1;
    l1_done = 1'b1;
    l2_done = 1'b1;
    wait_valid(40, n);
    @(posedge clk); #1;
    result_ready = 1'b0;
    l1_done = 1'b0;
    l2_done = 1'b0;
    @(negedge clk);
    chk("t3_results_left", 64'(res_q.size()), 64'd0);
    chk("t3_err_quiet", 64'(err), 64'd0);

`ifdef NN_SEQ_TIMEOUT_EN
    // Test 4: watchdog fires after 16 RUN cycles with l1_done never asserted.
    @(posedge clk); #1;
    push_pixels(784);
    pulse_start();
    stream(784, 1'b0, 1'b0);
    res_q.push_back('{cls: 4'hF, score: 64'd0});
    wait_valid(40, n);
    chk("t4_timeout_latency", 64'(n), 64'd17);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_l1_run_dropped", 64'(l1_run), 64'd0);
    @(posedge clk); #1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("t4_err_sticky", 64'(err), 64'd1);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("t4_err_cleared", 64'(err), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_q.delete();
    chk("t4_results_left", 64'(res_q.size()), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
